// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Divide-by-zero quotient is all ones. The top slices this to its own width,
  // so operand widths up to DIV_MAX_W are supported.
  localparam int unsigned DIV_MAX_W = 1024;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-and-subtract iteration: shift in a dividend bit, try the divisor.
module div_step #(
  parameter int n = 32
) (
  input  logic [n-1:0] i_rem,
  input  logic         i_msb,
  input  logic [n-1:0] i_div,
  output logic [n-1:0] o_rem,
  output logic         o_qbit
);

  logic [n:0] w_shift;
  logic [n:0] w_diff;

  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_div};

  // rem < divisor holds between steps, so w_shift < 2*divisor. A successful
  // subtract therefore leaves bit n clear, and a failed one always sets it,
  // which makes bit n an exact n+1-bit borrow.
  assign o_qbit = ~w_diff[n];
  assign o_rem  = o_qbit ? w_diff[n-1:0] : w_shift[n-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider retiring one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(n + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  div_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [n-1:0]     r_rem;
  logic [n-1:0]     r_dvd;
  logic [n-1:0]     r_div;
  logic [n-1:0]     r_q;
  logic [n-1:0]     r_r;
  logic             r_dbz;

  logic [n-1:0]     w_rem_nxt;
  logic             w_qbit;
  logic             w_accept;
  logic             w_last;

  div_step #(.n(n)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[n-1]),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_accept = start && (r_state != CALC);
  assign w_last   = (r_state == CALC) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_state_nxt = (b == '0) ? DONE : CALC;
        else       w_state_nxt = IDLE;
      end
      CALC:    w_state_nxt = w_last ? DONE : CALC;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_dvd <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_div <= b;
      if (b == '0) begin
        r_q   <= DIV_ZERO_Q[n-1:0];
        r_r   <= a;
        r_dbz <= 1'b1;
      end else begin
        r_rem <= '0;
        r_dvd <= a;
        r_cnt <= '0;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[n-2:0], w_qbit};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_q   <= {r_dvd[n-2:0], w_qbit};
        r_r   <= w_rem_nxt;
        r_dbz <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule
